// File: rtl/wb_issue_arbiter.sv
// -----------------------------------------------------------------------------
// wb_issue_arbiter
//   Producer side of the write-back path. Each execution source pushes results
//   into its own FIFO. A round-robin arbiter then issues at most one
//   write-back (index + data) per cycle toward the bypass buffer and the
//   register file. No issue happens while the global stall is asserted or while
//   the bypass buffer reports full.
//
// Ports
//   clock       : clock, all state changes on the rising edge
//   reset       : synchronous, active-high reset
//   I_Stall     : force stall, no issue this cycle
//   I_Full      : downstream bypass buffer full, no issue this cycle
//   I_Valid     : per-source result valid
//   I_Index     : per-source destination index, source s at [s*IDX_WIDTH +: IDX_WIDTH]
//   I_Data      : per-source result data, source s at [s*DATA_WIDTH +: DATA_WIDTH]
//   O_Ready     : per-source FIFO not full
//   O_WB_Valid  : write-back valid, a one-cycle pulse per result
//   O_WB_Index  : write-back register index
//   O_WB_Data   : write-back data
//   O_WB_Src    : source id of the issued result
//   O_Busy      : any FIFO non-empty or a write-back pulse in flight
// -----------------------------------------------------------------------------
module wb_issue_arbiter #(
  parameter int NUM_SRC    = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int IDX_WIDTH  = 8,
  parameter int DATA_WIDTH = 32,
  localparam int SRC_W     = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            I_Stall,
  input  logic                            I_Full,
  input  logic [NUM_SRC-1:0]              I_Valid,
  input  logic [NUM_SRC*IDX_WIDTH-1:0]    I_Index,
  input  logic [NUM_SRC*DATA_WIDTH-1:0]   I_Data,
  output logic [NUM_SRC-1:0]              O_Ready,
  output logic                            O_WB_Valid,
  output logic [IDX_WIDTH-1:0]            O_WB_Index,
  output logic [DATA_WIDTH-1:0]           O_WB_Data,
  output logic [SRC_W-1:0]                O_WB_Src,
  output logic                            O_Busy
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = IDX_WIDTH + DATA_WIDTH;

  // FIFO storage: each entry is {index, data}
  logic [ENT_W-1:0] mem_r    [NUM_SRC][FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_r [NUM_SRC];
  logic [PTR_W-1:0] rd_ptr_r [NUM_SRC];
  logic [CNT_W-1:0] count_r  [NUM_SRC];
  logic [SRC_W-1:0] rr_ptr_r;

  logic [NUM_SRC-1:0] ready_s;
  logic [NUM_SRC-1:0] eligible_s;
  logic [NUM_SRC-1:0] push_s;
  logic [NUM_SRC-1:0] pop_s;
  logic [SRC_W-1:0]   grant_s;
  logic               grant_vld_s;
  logic               en_s;
  logic               issue_s;
  logic [ENT_W-1:0]   head_s;

  assign en_s    = ~I_Stall & ~I_Full;
  assign issue_s = en_s & grant_vld_s;
  assign head_s  = mem_r[grant_s][rd_ptr_r[grant_s]];

  // Readiness, eligibility and push qualification all come from registered
  // counts, so a full FIFO refuses a push even in a cycle where it pops.
  always_comb begin
    ready_s    = '0;
    eligible_s = '0;
    push_s     = '0;
    pop_s      = '0;
    for (int s = 0; s < NUM_SRC; s++) begin
      ready_s[s]    = (count_r[s] < CNT_W'(FIFO_DEPTH));
      eligible_s[s] = (count_r[s] != '0);
      push_s[s]     = I_Valid[s] & ready_s[s];
      pop_s[s]      = issue_s & (grant_s == SRC_W'(s));
    end
  end

  // Round-robin pick: walk the sources from farthest to nearest after the RR
  // pointer, so the last match written is the first eligible one in cyclic order.
  always_comb begin
    int cand;
    cand        = 0;
    grant_s     = '0;
    grant_vld_s = 1'b0;
    for (int k = NUM_SRC; k >= 1; k--) begin
      cand = (int'(rr_ptr_r) + k) % NUM_SRC;
      if (eligible_s[cand]) begin
        grant_s     = SRC_W'(cand);
        grant_vld_s = 1'b1;
      end else begin
        grant_s     = grant_s;
        grant_vld_s = grant_vld_s;
      end
    end
  end

  // FIFO entry storage; contents are don't-care once the pointers reset.
  always_ff @(posedge clock) begin
    for (int s = 0; s < NUM_SRC; s++) begin
      if (push_s[s]) begin
        mem_r[s][wr_ptr_r[s]] <= {I_Index[s*IDX_WIDTH +: IDX_WIDTH],
                                  I_Data[s*DATA_WIDTH +: DATA_WIDTH]};
      end
    end
  end

  // Pointers, counts, round-robin state and the registered write-back outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int s = 0; s < NUM_SRC; s++) begin
        wr_ptr_r[s] <= '0;
        rd_ptr_r[s] <= '0;
        count_r[s]  <= '0;
      end
      rr_ptr_r   <= SRC_W'(NUM_SRC - 1);
      O_WB_Valid <= 1'b0;
      O_WB_Index <= '0;
      O_WB_Data  <= '0;
      O_WB_Src   <= '0;
    end else begin
      for (int s = 0; s < NUM_SRC; s++) begin
        if (push_s[s]) begin
          wr_ptr_r[s] <= wr_ptr_r[s] + PTR_W'(1);
        end
        if (pop_s[s]) begin
          rd_ptr_r[s] <= rd_ptr_r[s] + PTR_W'(1);
        end
        case ({push_s[s], pop_s[s]})
          2'b10:   count_r[s] <= count_r[s] + CNT_W'(1);
          2'b01:   count_r[s] <= count_r[s] - CNT_W'(1);
          default: count_r[s] <= count_r[s];
        endcase
      end
      // Each result pulses exactly once; index/data/src hold between pulses.
      if (issue_s) begin
        O_WB_Valid <= 1'b1;
        O_WB_Index <= head_s[ENT_W-1 -: IDX_WIDTH];
        O_WB_Data  <= head_s[DATA_WIDTH-1:0];
        O_WB_Src   <= grant_s;
        rr_ptr_r   <= grant_s;
      end else begin
        O_WB_Valid <= 1'b0;
      end
    end
  end

  assign O_Ready = ready_s;
  assign O_Busy  = (|eligible_s) | O_WB_Valid;

endmodule

// File: tb/tb_wb_issue_arbiter.sv
module tb_wb_issue_arbiter;

  localparam int NS    = 2;
  localparam int DEPTH = 4;

  logic        clock;
  logic        reset;
  logic        I_Stall;
  logic        I_Full;
  logic [1:0]  I_Valid;
  logic [15:0] I_Index;
  logic [63:0] I_Data;
  logic [1:0]  O_Ready;
  logic        O_WB_Valid;
  logic [7:0]  O_WB_Index;
  logic [31:0] O_WB_Data;
  logic [0:0]  O_WB_Src;
  logic        O_Busy;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  wb_issue_arbiter #(
    .NUM_SRC(NS), .FIFO_DEPTH(DEPTH), .IDX_WIDTH(8), .DATA_WIDTH(32)
  ) dut (
    .clock(clock), .reset(reset), .I_Stall(I_Stall), .I_Full(I_Full),
    .I_Valid(I_Valid), .I_Index(I_Index), .I_Data(I_Data),
    .O_Ready(O_Ready), .O_WB_Valid(O_WB_Valid), .O_WB_Index(O_WB_Index),
    .O_WB_Data(O_WB_Data), .O_WB_Src(O_WB_Src), .O_Busy(O_Busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model: per-source queues + RR pointer ----------
  typedef logic [39:0] ent_t;
  ent_t        mq0[$];
  ent_t        mq1[$];
  int          m_rr;
  logic        m_v;
  logic [7:0]  m_i;
  logic [31:0] m_d;
  int          m_s;
  bit          m_on = 1'b0;

  function automatic int qsize(input int s);
    return (s == 0) ? mq0.size() : mq1.size();
  endfunction

  initial forever begin
    int   pre[NS];
    int   g;
    ent_t e;
    @(posedge clock);
    cyc++;
    if (reset) begin
      mq0.delete(); mq1.delete();
      m_rr = NS - 1; m_v = 1'b0; m_i = 8'h00; m_d = 32'h0; m_s = 0;
      m_on = 1'b1;
    end else if (m_on) begin
      for (int s = 0; s < NS; s++) pre[s] = qsize(s);
      g = -1;
      if (!I_Stall && !I_Full) begin
        for (int k = 1; k <= NS; k++) begin
          if (g < 0 && pre[(m_rr + k) % NS] > 0) g = (m_rr + k) % NS;
        end
      end
      if (g >= 0) begin
        e = (g == 0) ? mq0.pop_front() : mq1.pop_front();
        m_v = 1'b1; m_i = e[39:32]; m_d = e[31:0]; m_s = g; m_rr = g;
      end else begin
        m_v = 1'b0;
      end
      for (int s = 0; s < NS; s++) begin
        if (I_Valid[s] && pre[s] < DEPTH) begin
          e = {I_Index[s*8 +: 8], I_Data[s*32 +: 32]};
          if (s == 0) mq0.push_back(e); else mq1.push_back(e);
        end
      end
    end
  end

  // ---------------- per-cycle compare against the model ---------------------
  initial forever begin
    logic [1:0] exp_rdy;
    @(negedge clock);
    if (m_on) begin
      for (int s = 0; s < NS; s++) exp_rdy[s] = (qsize(s) < DEPTH);
      check("wb_valid", 64'(O_WB_Valid), 64'(m_v));
      check("wb_index", 64'(O_WB_Index), 64'(m_i));
      check("wb_data",  64'(O_WB_Data),  64'(m_d));
      check("wb_src",   64'(O_WB_Src),   64'(m_s));
      check("ready",    64'(O_Ready),    64'(exp_rdy));
      check("busy",     64'(O_Busy),     64'((mq0.size() + mq1.size() > 0) || m_v));
    end
  end

  // ---------------- pulse monitor (observed write-backs) ---------------------
  int          pq_src[$];
  logic [31:0] pq_data[$];
  int          pq_cyc[$];

  initial forever begin
    @(negedge clock);
    if (O_WB_Valid === 1'b1) begin
      pq_src.push_back(int'(O_WB_Src));
      pq_data.push_back(O_WB_Data);
      pq_cyc.push_back(cyc);
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; I_Valid = 2'b00; I_Stall = 1'b0; I_Full = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic clear_pulses();
    pq_src.delete(); pq_data.delete(); pq_cyc.delete();
  endtask

  // ---------------- stimulus ---------------------------------------------------
  initial begin
    reset = 1'b1; I_Stall = 1'b0; I_Full = 1'b0;
    I_Valid = 2'b00; I_Index = 16'h0; I_Data = 64'h0;
    repeat (2) tick();
    reset = 1'b0;
    @(negedge clock);
    check("rst_valid", 64'(O_WB_Valid), 64'd0);
    check("rst_ready", 64'(O_Ready), 64'h3);
    check("rst_busy",  64'(O_Busy), 64'd0);

    // Single result: push at edge t, pulse after edge t+1
    tick();
    I_Valid = 2'b01; I_Index = 16'h0005; I_Data = {32'h0, 32'hDEADBEEF};
    tick();
    I_Valid = 2'b00;
    @(negedge clock);
    check("t1_no_bypass", 64'(O_WB_Valid), 64'd0);
    tick();
    @(negedge clock);
    check("t1_valid", 64'(O_WB_Valid), 64'd1);
    check("t1_index", 64'(O_WB_Index), 64'h05);
    check("t1_data",  64'(O_WB_Data), 64'hDEADBEEF);
    check("t1_src",   64'(O_WB_Src), 64'd0);
    tick();
    @(negedge clock);
    check("t1_pulse_end", 64'(O_WB_Valid), 64'd0);
    check("t1_idle",      64'(O_Busy), 64'd0);

    // Both sources push every cycle: alternating grants, per-source order
    do_reset();
    clear_pulses();
    for (int k = 0; k < 4; k++) begin
      I_Valid = 2'b11;
      I_Index = {8'(8'h10 + k), 8'(k)};
      I_Data  = {32'h1000_0000 + 32'(k), 32'(k)};
      tick();
    end
    I_Valid = 2'b00;
    repeat (10) tick();
    check("t2_count", 64'(pq_src.size()), 64'd8);
    for (int i = 0; i < pq_src.size() && i < 8; i++) begin
      check("t2_src",  64'(pq_src[i]), 64'(i % 2));
      check("t2_data", 64'(pq_data[i]), 64'(((i % 2) == 1 ? 32'h1000_0000 : 32'h0) + 32'(i / 2)));
    end

    // Downstream full holds off issue, then both entries drain once
    do_reset();
    clear_pulses();
    I_Full = 1'b1;
    I_Valid = 2'b01; I_Data = 64'hA0; tick();
    I_Data = 64'hA1; tick();
    I_Valid = 2'b00;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check("t3_full_hold", 64'(O_WB_Valid), 64'd0);
      tick();
    end
    I_Full = 1'b0;
    tick();
    @(negedge clock);
    check("t3_first",  64'(O_WB_Data), 64'hA0);
    check("t3_first_v", 64'(O_WB_Valid), 64'd1);
    tick();
    @(negedge clock);
    check("t3_second", 64'(O_WB_Data), 64'hA1);
    tick();
    @(negedge clock);
    check("t3_done", 64'(O_WB_Valid), 64'd0);
    check("t3_count", 64'(pq_src.size()), 64'd2);

    // Stall fills src1 to depth; fifth result waits until the first pop
    do_reset();
    clear_pulses();
    I_Stall = 1'b1;
    for (int k = 0; k < 5; k++) begin
      I_Valid = 2'b10; I_Data = {32'hB0 + 32'(k), 32'h0};
      tick();
      @(negedge clock);
      check("t4_ready", 64'(O_Ready[1]), 64'(k < 3));
    end
    tick();
    I_Stall = 1'b0;
    tick();
    @(negedge clock);
    check("t4_ready_back", 64'(O_Ready[1]), 64'd1);
    check("t4_first", 64'(O_WB_Data), 64'hB0);
    tick();
    I_Valid = 2'b00;
    repeat (6) tick();
    check("t4_count", 64'(pq_src.size()), 64'd5);
    for (int i = 0; i < pq_data.size() && i < 5; i++) begin
      check("t4_order", 64'(pq_data[i]), 64'(32'hB0 + 32'(i)));
    end

    // Reset mid-operation discards queued work
    do_reset();
    I_Stall = 1'b1;
    for (int k = 0; k < 4; k++) begin
      I_Valid = 2'b01; I_Data = 64'hC0 + 64'(k); tick();
    end
    I_Valid = 2'b00; I_Stall = 1'b0;
    tick();
    @(negedge clock);
    check("t5_pre_valid", 64'(O_WB_Valid), 64'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clock);
    check("t5_valid", 64'(O_WB_Valid), 64'd0);
    check("t5_index", 64'(O_WB_Index), 64'd0);
    check("t5_data",  64'(O_WB_Data), 64'd0);
    check("t5_src",   64'(O_WB_Src), 64'd0);
    check("t5_ready", 64'(O_Ready), 64'h3);
    check("t5_busy",  64'(O_Busy), 64'd0);
    clear_pulses();
    repeat (3) tick();
    check("t5_no_issue", 64'(pq_src.size()), 64'd0);

    // Only src1 active with RR pointer at 0: back-to-back grants
    do_reset();
    I_Valid = 2'b01; I_Data = 64'hEE; tick();
    I_Valid = 2'b00; tick();
    @(negedge clock);
    #1;
    clear_pulses();
    for (int k = 0; k < 6; k++) begin
      I_Valid = 2'b10; I_Data = {32'hD0 + 32'(k), 32'h0};
      tick();
    end
    I_Valid = 2'b00;
    repeat (4) tick();
    check("t6_count", 64'(pq_src.size()), 64'd6);
    for (int i = 0; i < pq_src.size() && i < 6; i++) begin
      check("t6_src",  64'(pq_src[i]), 64'd1);
      check("t6_data", 64'(pq_data[i]), 64'(32'hD0 + 32'(i)));
      check("t6_gap",  64'(pq_cyc[i] - pq_cyc[0]), 64'(i));
    end

    // Randomized traffic with occasional stall, full and reset
    for (int i = 0; i < 3000; i++) begin
      I_Valid = 2'($urandom_range(0, 3));
      I_Index = 16'($urandom);
      I_Data  = {$urandom, $urandom};
      I_Stall = ($urandom_range(0, 4) == 0);
      I_Full  = ($urandom_range(0, 4) == 0);
      reset   = ($urandom_range(0, 199) == 0);
      tick();
    end
    reset = 1'b0; I_Valid = 2'b00; I_Stall = 1'b0; I_Full = 1'b0;
    repeat (12) tick();
    @(negedge clock);
    check("drain_busy", 64'(O_Busy), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
